// File: rtl/mld_cyclic_encoder.sv
// Serial systematic (N,K) cyclic-code encoder: streams K message bits then N-K parity
// bits through a single valid/ready holding slot, and latches the parity of each frame.
module mld_cyclic_encoder #(
    parameter int N = 15,
    parameter int K = 7,
    parameter logic [N-K:0] GEN_POLY = 9'h1D1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             information_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [N-K-1:0]   parity_vector,
    output logic             parity_valid
);

    localparam int P  = N - K;
    localparam int CW = $clog2(N);

    localparam logic ST_MSG = 1'b0;
    localparam logic ST_PAR = 1'b1;

    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] P_LAST = CW'(P - 1);

    if (N <= K) begin : g_bad_nk
        $error("mld_cyclic_encoder: N must be greater than K");
    end
    if (GEN_POLY[N-K] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
        $error("mld_cyclic_encoder: GEN_POLY must have its x^(N-K) and x^0 terms set");
    end

    logic          state;
    logic [CW-1:0] cnt;
    logic [P-1:0]  r;

    logic          slot_free;
    logic          accept;
    logic          fb;
    logic [P-1:0]  r_shift;
    logic [P-1:0]  r_msg_next;

    // The slot may be reloaded in the same cycle its current bit is taken downstream.
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = (state == ST_MSG) && slot_free && !clear;
    assign accept     = in_valid && in_ready;

    assign fb         = information_bit ^ r[P-1];
    assign r_shift    = r << 1;
    assign r_msg_next = r_shift ^ (fb ? GEN_POLY[P-1:0] : '0);

    // NOTE: every register here is updated with <= so all of them see the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_MSG;
            cnt           <= '0;
            r             <= '0;
            out_bit       <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            parity_vector <= '0;
            parity_valid  <= 1'b0;
        end else begin
            parity_valid <= 1'b0;
            if (clear) begin
                state     <= ST_MSG;
                cnt       <= '0;
                r         <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (state == ST_MSG) begin
                if (accept) begin
                    out_bit   <= information_bit;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    r         <= r_msg_next;
                    if (cnt == K_LAST) begin
                        cnt           <= '0;
                        state         <= ST_PAR;
                        parity_vector <= r_msg_next;
                        parity_valid  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end else if (slot_free) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (slot_free) begin
                // Parity phase: the remainder register shifts out MSB first and ends empty.
                out_bit   <= r[P-1];
                out_valid <= 1'b1;
                r         <= r_shift;
                if (cnt == P_LAST) begin
                    out_last <= 1'b1;
                    cnt      <= '0;
                    state    <= ST_MSG;
                end else begin
                    out_last <= 1'b0;
                    cnt      <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mld_cyclic_encoder.sv
// Self-checking bench for mld_cyclic_encoder in its default (15,7) configuration:
// table-driven frames, hand-written reset/clear/back-to-back sequences and random backpressure.
module tb_mld_cyclic_encoder;

    localparam logic [8:0] GEN = 9'h1D1;

    typedef struct {
        logic [6:0] msg;
        logic [7:0] par;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       information_bit;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] parity_vector;
    logic       parity_valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_ready = 0;

    logic       cap_bits[$];
    logic       cap_last[$];
    int         cap_cyc[$];
    logic [7:0] pv_q[$];
    logic [7:0] exp_pv;

    mld_cyclic_encoder dut (
        .clk             (clk),
        .reset           (reset),
        .clear           (clear),
        .information_bit (information_bit),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_bit         (out_bit),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .parity_vector   (parity_vector),
        .parity_valid    (parity_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: long division of x^8*m(x) by g(x) over GF(2).
    function automatic logic [14:0] encode(input logic [6:0] m);
        logic [14:0] d;
        d = {m, 8'b0};
        for (int i = 14; i >= 8; i--)
            if (d[i]) d = d ^ (15'(GEN) << (i - 8));
        return {m, d[7:0]};
    endfunction

    // Outputs are observed on the falling edge; a valid&&ready seen here completes on the next rise.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (out_valid && out_ready) begin
                cap_bits.push_back(out_bit);
                cap_last.push_back(out_last);
                cap_cyc.push_back(cyc);
            end
            if (parity_valid) pv_q.push_back(parity_vector);
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic flush();
        cap_bits.delete();
        cap_last.delete();
        cap_cyc.delete();
    endtask

    task automatic push_bit(input logic b);
        bit done;
        done = 0;
        information_bit = b;
        in_valid = 1'b1;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        check("push_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_msg(input logic [6:0] m, input bit gaps);
        for (int i = 6; i >= 0; i--) begin
            push_bit(m[i]);
            if (gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_bits(input int n);
        int t;
        t = 0;
        while (cap_bits.size() < n && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wait_bits_timeout", 32'(cap_bits.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int first, input logic [14:0] exp_cw);
        logic [14:0] cw;
        logic [14:0] lm;
        cw = '0;
        lm = '0;
        if (cap_bits.size() >= first + 15) begin
            for (int i = first; i < first + 15; i++) begin
                cw = {cw[13:0], cap_bits[i]};
                lm = {lm[13:0], cap_last[i]};
            end
            check({tag, "_codeword"}, 32'(cw), 32'(exp_cw));
            check({tag, "_last"}, 32'(lm), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[4];
        logic [6:0] rmsg[6];
        int pv_before;

        tbl[0] = '{msg: 7'b0000001, par: 8'hD1};
        tbl[1] = '{msg: 7'b1110100, par: 8'h40};
        tbl[2] = '{msg: 7'b1110101, par: 8'h91};
        tbl[3] = '{msg: 7'b0000000, par: 8'h00};

        reset = 1'b1;
        clear = 1'b0;
        information_bit = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_pv = 8'h00;

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit", 32'(out_bit), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_parity_vector", 32'(parity_vector), 32'd0);
        check("rst_parity_valid", 32'(parity_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Table of known frames, out_ready held high.
        foreach (tbl[v]) begin
            flush();
            pv_before = pv_q.size();
            send_msg(tbl[v].msg, 0);
            in_valid = 1'b0;
            wait_bits(15);
            check_frame($sformatf("tbl%0d", v), 0, {tbl[v].msg, tbl[v].par});
            check($sformatf("tbl%0d_parity_vector", v), 32'(parity_vector), 32'(tbl[v].par));
            check($sformatf("tbl%0d_parity_pulses", v), 32'(pv_q.size() - pv_before), 32'd1);
            exp_pv = tbl[v].par;
        end

        // Two frames back to back with in_valid never dropped.
        flush();
        rmsg[0] = 7'($urandom);
        rmsg[1] = 7'($urandom);
        send_msg(rmsg[0], 0);
        send_msg(rmsg[1], 0);
        in_valid = 1'b0;
        wait_bits(30);
        if (cap_cyc.size() >= 30)
            check("b2b_no_bubble", 32'(cap_cyc[29] - cap_cyc[0]), 32'd29);
        check_frame("b2b_f0", 0, encode(rmsg[0]));
        check_frame("b2b_f1", 15, encode(rmsg[1]));
        exp_pv = encode(rmsg[1]) & 15'h00FF;

        // Random backpressure and input gaps.
        flush();
        rand_ready = 1;
        foreach (rmsg[i]) begin
            rmsg[i] = 7'($urandom);
            send_msg(rmsg[i], 1);
        end
        in_valid = 1'b0;
        rand_ready = 0;
        out_ready = 1'b1;
        wait_bits(90);
        check("rand_count", 32'(cap_bits.size()), 32'd90);
        foreach (rmsg[i]) check_frame($sformatf("rand_f%0d", i), 15 * i, encode(rmsg[i]));
        exp_pv = encode(rmsg[5]) & 15'h00FF;
        check("rand_parity_vector", 32'(parity_vector), 32'(exp_pv));

        // Clear after four message bits, then a clean frame.
        flush();
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        push_bit(1'b1);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_out_valid", 32'(out_valid), 32'd0);
        check("clear_out_last", 32'(out_last), 32'd0);
        check("clear_parity_kept", 32'(parity_vector), 32'(exp_pv));
        flush();
        send_msg(7'b0000001, 0);
        in_valid = 1'b0;
        wait_bits(15);
        check_frame("post_clear", 0, 15'b000000111010001);
        check("post_clear_parity", 32'(parity_vector), 32'hD1);
        check("post_clear_count", 32'(cap_bits.size()), 32'd15);

        // Asynchronous reset three bits into a frame.
        flush();
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_bit", 32'(out_bit), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_parity_vector", 32'(parity_vector), 32'd0);
        check("midrst_parity_valid", 32'(parity_valid), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush();
        pv_before = pv_q.size();
        send_msg(7'b0000001, 0);
        in_valid = 1'b0;
        wait_bits(15);
        check_frame("post_rst", 0, 15'b000000111010001);
        check("post_rst_parity", 32'(parity_vector), 32'hD1);
        check("post_rst_pulses", 32'(pv_q.size() - pv_before), 32'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
